// File: rtl/romarb_rr_if.sv
// romarb_rr_if: bundle of the channel-side and ROM-side handshake signals of
// the round-robin ROM arbiter.
//   chaddr/chreq    : per-channel read address (channel i in slice i) and request
//   chack/chdata    : per-channel one-cycle acknowledge and shared read data
//   romaddr/romreq  : external ROM address and level request
//   romack/romdata  : external one-cycle acknowledge and data
//   busy            : arbiter is not idle
// Modports: slave = arbiter side, master = fetcher/ROM environment side.
interface romarb_rr_if #(
  parameter int NCH = 4,
  parameter int CAW = 21,
  parameter int RAW = 22
);
  logic [NCH-1:0][CAW-1:0] chaddr;
  logic [NCH-1:0]          chreq;
  logic [NCH-1:0]          chack;
  logic [7:0]              chdata;
  logic [RAW-1:0]          romaddr;
  logic                    romreq;
  logic                    romack;
  logic [7:0]              romdata;
  logic                    busy;

  modport slave  (input  chaddr, chreq, romack, romdata,
                  output chack, chdata, romaddr, romreq, busy);
  modport master (output chaddr, chreq, romack, romdata,
                  input  chack, chdata, romaddr, romreq, busy);
endinterface

// File: rtl/romarb_rr.sv
// romarb_rr: round-robin arbiter of NCH read-request channels onto a single
// external ROM port. Channel i addresses are offset by slice i of BASE
// (sum truncated to RAW bits).
// Ports:
//   clk      : system clock
//   reset_n  : synchronous active-low reset
//   bus      : romarb_rr_if.slave (channel requests/acks, ROM port, busy)
// Optional feature: define ROMARB_RR_CACHE_EN to add a per-channel
// last-address/last-data cache; a hit answers without touching the ROM port.
module romarb_rr #(
  parameter int                 NCH  = 4,
  parameter int                 CAW  = 21,
  parameter int                 RAW  = 22,
  parameter logic [NCH*RAW-1:0] BASE = '0
) (
  input  logic       clk,
  input  logic       reset_n,
  romarb_rr_if.slave bus
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]     r_state;
  logic [PW-1:0]  r_ptr;
  logic [PW-1:0]  r_g;
  logic [NCH-1:0] r_chack;
  logic [7:0]     r_chdata;
  logic [RAW-1:0] r_romaddr;
  logic           r_romreq;

  logic           w_found;
  logic [PW-1:0]  w_pick;
  logic [RAW-1:0] w_addr;
  int             w_idx;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] g);
    return (int'(g) == NCH - 1) ? '0 : g + 1'b1;
  endfunction

  // First requesting channel at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      w_idx = (int'(r_ptr) + k) % NCH;
      if (!w_found && bus.chreq[w_idx]) begin
        w_found = 1'b1;
        w_pick  = PW'(w_idx);
      end
    end
  end

  // Offset add wraps modulo 2^RAW.
  assign w_addr = BASE[int'(w_pick)*RAW +: RAW] + RAW'(bus.chaddr[w_pick]);

`ifdef ROMARB_RR_CACHE_EN
  logic [NCH-1:0]          r_cv;
  logic [NCH-1:0][CAW-1:0] r_ca;
  logic [NCH-1:0][7:0]     r_cd;
  logic [CAW-1:0]          r_gaddr;
  logic                    w_hit;

  assign w_hit = r_cv[w_pick] && (r_ca[w_pick] == bus.chaddr[w_pick]);

  // Only the channel whose ROM access just completed is refreshed. The
  // address tag is the channel address captured at grant, so a withdrawn
  // request still leaves a consistent entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cv <= '0;
    end else if (r_state == S_ISSUE && bus.romack) begin
      r_cv[r_g] <= 1'b1;
      r_ca[r_g] <= r_gaddr;
      r_cd[r_g] <= bus.romdata;
    end
    if (r_state == S_IDLE && w_found) r_gaddr <= bus.chaddr[w_pick];
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_g       <= '0;
      r_chack   <= '0;
      r_chdata  <= '0;
      r_romaddr <= '0;
      r_romreq  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_found) begin
          r_g <= w_pick;
`ifdef ROMARB_RR_CACHE_EN
          if (w_hit) begin
            r_chack  <= NCH'(1) << w_pick;
            r_chdata <= r_cd[w_pick];
            r_ptr    <= f_next(w_pick);
            r_state  <= S_DONE;
          end else
`endif
          begin
            r_romaddr <= w_addr;
            r_romreq  <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        // The access completes even if the requester withdrew meanwhile,
        // so the ROM port never keeps a dangling request.
        S_ISSUE: if (bus.romack) begin
          r_romreq <= 1'b0;
          r_chdata <= bus.romdata;
          r_chack  <= NCH'(1) << r_g;
          r_ptr    <= f_next(r_g);
          r_state  <= S_DONE;
        end
        // No arbitration here: the served channel's stale request is ignored.
        S_DONE: begin
          r_chack <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.chack   = r_chack;
  assign bus.chdata  = r_chdata;
  assign bus.romaddr = r_romaddr;
  assign bus.romreq  = r_romreq;
  assign bus.busy    = (r_state != S_IDLE);
endmodule

// File: tb/tb_romarb_rr.sv
module tb_romarb_rr;
  localparam int NCH = 4;
  localparam int CAW = 21;
  localparam int RAW = 22;
  localparam logic [NCH*RAW-1:0] BASE = {22'h3FFFF0, 22'h010000, 22'h000100, 22'h000000};

  logic clk = 1'b0;
  logic reset_n;
  romarb_rr_if #(.NCH(NCH), .CAW(CAW), .RAW(RAW)) bus ();

  romarb_rr #(.NCH(NCH), .CAW(CAW), .RAW(RAW), .BASE(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // reference model: transaction phase 0=free, 1=ROM access pending, 2=ack cycle
  logic [RAW-1:0] m_base [NCH];
  int             m_ph, m_ptr, m_g;
  logic [RAW-1:0] m_a;
  logic [7:0]     m_chd;
  logic [CAW-1:0] m_ga;
  logic [NCH-1:0] m_ack_exp;
  bit             m_cv [NCH];
  logic [CAW-1:0] m_ca [NCH];
  logic [7:0]     m_cd [NCH];

  // environment controls
  int       rom_lat, rom_cnt, rq_cnt;
  bit       rom_en, junk_en, fix_en, auto_req;
  logic [7:0] rom_fix;
  logic [3:0] rr_exp [5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic int pick(input logic [NCH-1:0] r, input int p);
    for (int k = 0; k < NCH; k++)
      if (r[(p + k) % NCH]) return (p + k) % NCH;
    return -1;
  endfunction

  // One clock: sample inputs seen at the edge, advance the model, check all
  // outputs, then let the ROM responder and random requesters react.
  task automatic tick();
    logic [NCH-1:0] req_s;
    logic [NCH-1:0][CAW-1:0] addr_s;
    logic ack_s, rst_s;
    logic [7:0] dat_s;
    int g;
    req_s = bus.chreq; addr_s = bus.chaddr; ack_s = bus.romack;
    dat_s = bus.romdata; rst_s = reset_n;
    @(posedge clk); #1;
    m_ack_exp = '0;
    if (!rst_s) begin
      m_ph = 0; m_ptr = 0; m_chd = '0;
      for (int i = 0; i < NCH; i++) m_cv[i] = 1'b0;
      chk("rst_romaddr", bus.romaddr, 0);
    end else begin
      case (m_ph)
        0: begin
          g = pick(req_s, m_ptr);
          if (g >= 0) begin
            m_g = g; m_ga = addr_s[g];
            m_a = m_base[g] + RAW'(addr_s[g]);
`ifdef ROMARB_RR_CACHE_EN
            if (m_cv[g] && m_ca[g] == m_ga) begin
              m_ph = 2; m_ack_exp[g] = 1'b1; m_chd = m_cd[g]; m_ptr = (g + 1) % NCH;
            end else
`endif
            m_ph = 1;
          end
        end
        1: if (ack_s) begin
          m_ph = 2; m_ack_exp[m_g] = 1'b1; m_chd = dat_s; m_ptr = (m_g + 1) % NCH;
          m_cv[m_g] = 1'b1; m_ca[m_g] = m_ga; m_cd[m_g] = dat_s;
        end
        default: m_ph = 0;
      endcase
    end
    chk("romreq", bus.romreq, 32'(m_ph == 1));
    chk("chack", bus.chack, m_ack_exp);
    chk("chdata", bus.chdata, m_chd);
    chk("busy", bus.busy, 32'(m_ph != 0));
    chk("onehot", $onehot0(bus.chack), 1);
    if (m_ph == 1) chk("romaddr", bus.romaddr, m_a);
    if (bus.romreq) rq_cnt++;

    // ROM responder; junk acks while no request is pending must be ignored
    if (bus.romack) bus.romack = 1'b0;
    else if (bus.romreq && rom_en) begin
      rom_cnt++;
      if (rom_cnt >= rom_lat) begin
        bus.romack = 1'b1;
        bus.romdata = fix_en ? rom_fix : 8'($urandom);
        rom_cnt = 0;
        if (auto_req) rom_lat = $urandom_range(1, 4);
      end
    end else begin
      rom_cnt = 0;
      if (junk_en && !bus.romreq && $urandom_range(3) == 0) begin
        bus.romack = 1'b1; bus.romdata = 8'($urandom);
      end
    end

    if (auto_req)
      for (int i = 0; i < NCH; i++) begin
        if (bus.chreq[i] && bus.chack[i]) bus.chreq[i] = 1'b0;
        else if (!bus.chreq[i] && $urandom_range(2) == 0) begin
          bus.chaddr[i] = ($urandom_range(3) == 0) ? CAW'($urandom) : CAW'($urandom_range(3));
          bus.chreq[i] = 1'b1;
        end else if (bus.chreq[i] && m_ph == 1 && i == m_g && $urandom_range(15) == 0)
          bus.chreq[i] = 1'b0;
      end
  endtask

  // ch < 0 waits for any acknowledge
  task automatic wait_chack(input int ch, input int lim, input string tag, output int n);
    bit f;
    f = 1'b0; n = 0;
    while (!f && n < lim) begin
      tick(); n++;
      if (ch < 0 ? (|bus.chack) : bus.chack[ch]) f = 1'b1;
    end
    chk(tag, 32'(f), 1);
  endtask

  int n, c0;
  logic [7:0] d1;

  initial begin
    m_base = '{22'h000000, 22'h000100, 22'h010000, 22'h3FFFF0};
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    m_ph = 0; m_ptr = 0; m_g = 0; m_chd = '0; rq_cnt = 0; rom_cnt = 0;
    reset_n = 1'b0; bus.chreq = '0; bus.chaddr = '0; bus.romack = 1'b0; bus.romdata = '0;
    rom_en = 1; rom_lat = 1; junk_en = 0; fix_en = 0; auto_req = 0; rom_fix = '0;
    tick(); tick();
    chk("reset_chack", bus.chack, 0);
    reset_n = 1'b1; tick();

    // single request on channel 2
    fix_en = 1; rom_fix = 8'hA5; rom_lat = 3;
    bus.chaddr[2] = 21'h0123; bus.chreq[2] = 1'b1;
    tick();
    chk("single_romreq", bus.romreq, 1);
    chk("single_addr", bus.romaddr, 22'h010123);
    wait_chack(2, 10, "single_ack", n);
    chk("single_chack", bus.chack, 4'b0100);
    chk("single_data", bus.chdata, 8'hA5);
    chk("single_reqfall", bus.romreq, 0);
    bus.chreq[2] = 1'b0;
    tick();
    chk("single_pulse", bus.chack, 0);
    chk("single_hold", bus.chdata, 8'hA5);

    // reset in the middle of a ROM access, ack arrives during and after reset
    fix_en = 0; rom_en = 0;
    bus.chaddr[1] = 21'h42; bus.chreq[1] = 1'b1;
    tick();
    chk("rstmid_req", bus.romreq, 1);
    reset_n = 1'b0; tick();
    chk("rstmid_drop", bus.romreq, 0);
    bus.romack = 1'b1; bus.romdata = 8'h77; tick();
    chk("rstmid_chdata", bus.chdata, 0);
    bus.chreq[1] = 1'b0; reset_n = 1'b1;
    bus.romack = 1'b1; tick();
    chk("late_ack", bus.chack, 0);
    repeat (3) tick();

    // round robin with all channels held
    rom_en = 1; rom_lat = 1;
    for (int i = 0; i < NCH; i++) bus.chaddr[i] = CAW'($urandom);
    bus.chreq = '1;
    for (int p = 0; p < 5; p++) begin
      wait_chack(-1, 12, "rr_ack", n);
      chk("rr_order", bus.chack, rr_exp[p]);
    end
    bus.chreq = '0; tick(); tick();

    // base + address wraps past the top of ROM space
    bus.chaddr[3] = 21'h20; bus.chreq[3] = 1'b1;
    tick();
    chk("wrap_addr", bus.romaddr, 22'h000010);
    wait_chack(3, 10, "wrap_ack", n);
    bus.chreq[3] = 1'b0; tick();

    // withdrawal during the ROM access
    rom_lat = 4;
    bus.chaddr[1] = 21'h777; bus.chreq[1] = 1'b1;
    tick();
    chk("wd_req", bus.romreq, 1);
    bus.chreq[1] = 1'b0; tick();
    chk("wd_still_req", bus.romreq, 1);
    wait_chack(1, 10, "wd_ack", n);
    chk("wd_chack", bus.chack, 4'b0010);
    bus.chaddr[0] = 21'h9; bus.chreq[0] = 1'b1;
    wait_chack(0, 12, "wd_next_ack", n);
    bus.chreq[0] = 1'b0; tick();

    // repeated read of the same address on channel 0
    reset_n = 1'b0; tick(); reset_n = 1'b1; rom_lat = 2;
    bus.chaddr[0] = 21'h55; bus.chreq[0] = 1'b1; c0 = rq_cnt;
    wait_chack(0, 12, "c1_ack", n);
    d1 = bus.chdata;
    bus.chreq[0] = 1'b0; tick();
    chk("c1_rom", 32'(rq_cnt > c0), 1);
    c0 = rq_cnt; bus.chreq[0] = 1'b1;
    wait_chack(0, 12, "c2_ack", n);
`ifdef ROMARB_RR_CACHE_EN
    chk("c2_lat", n, 1);
    chk("c2_data", bus.chdata, d1);
    chk("c2_norom", rq_cnt - c0, 0);
`else
    chk("c2_rom", 32'(rq_cnt > c0), 1);
`endif
    bus.chreq[0] = 1'b0; tick();
    c0 = rq_cnt; bus.chaddr[0] = 21'h56; bus.chreq[0] = 1'b1;
    wait_chack(0, 12, "c3_ack", n);
    chk("c3_rom", 32'(rq_cnt > c0), 1);
    bus.chreq[0] = 1'b0; tick();

    // random traffic with spurious acks and random ROM latency
    junk_en = 1; auto_req = 1;
    repeat (400) tick();
    auto_req = 0; junk_en = 0; bus.chreq = '0;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/romarb_rr.md
Name: romarb_rr

Overview:
- Parametrised successor to the two-port ROM arbiter in the NES core.
- Arbitrates NCH read-request channels onto the single external ROM port. Channels are PRG, CHR, and future mapper/APU/header fetchers.
- Round-robin fairness; per-channel base offset into the 22-bit ROM space.
- Sits between mmc-side fetchers and the top-level romaddr/romdata/romreq/romack pins.

Parameters:
- NCH, 4, number of request channels (2..8).
- CAW, 21, per-channel address width (≤22).
- RAW, 22, external ROM address width.
- BASE, 0, packed NCH*RAW vector; slice i is the ROM offset added to channel i addresses.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- chaddr  in  NCH*CAW  packed channel addresses; slice i belongs to channel i.
- chreq  in  NCH  per-channel read request, level.
- chack  out  NCH  per-channel one-cycle acknowledge; data valid in the same cycle.
- chdata  out  8  shared read data, valid when any chack bit is high.
- romaddr  out  RAW  external address.
- romreq  out  1  external request, level.
- romack  in  1  external one-cycle acknowledge.
- romdata  in  8  external data, valid when romack=1.
- busy  out  1  high when state≠IDLE.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE; romreq=0; romaddr=0; chack=0; chdata=0.
  - Round-robin pointer ptr=0; grant g=0.
  - Reset mid-transaction abandons it. A late romack is ignored.
- Requester rules:
  - Hold chreq[i]=1 with chaddr[i] stable until chack[i] is seen.
  - Drop or change the request at the edge where chack[i] is sampled.
- FSM:
  - IDLE:
    - If any chreq bit is set, pick the first requesting channel at or after ptr, wrapping modulo NCH.
    - Register g, romaddr=BASE[g]+chaddr[g] (truncated to RAW bits, wrap-around), romreq=1.
    - Next state ISSUE.
  - ISSUE:
    - romreq held at 1 and romaddr stable.
    - On romack=1: romreq=0, chdata=romdata, chack[g]=1, ptr=(g+1) mod NCH. Next state DONE.
  - DONE:
    - chack returns to 0 (exactly one cycle high); chdata holds its value.
    - Next state IDLE. No arbitration in DONE, so a just-served channel cannot be re-granted on its stale request.
- Latency:
  - chreq rise at edge t → romreq high after edge t+1.
  - romack at edge t+k → chack after that edge.
  - Minimum 3 cycles per transaction, request to next possible grant.
- Fairness: with all NCH requesting continuously, grants cycle 0,1,…,NCH-1,0.
- Withdrawn request: if chreq[g] falls during ISSUE, the ROM access still completes. chack[g] still pulses; the requester ignores it. The ROM port is never left with a dangling req.
- romack while IDLE or DONE is ignored.
- At most one chack bit is high in any cycle.

Optional Feature:
- Macro: ROMARB_RR_CACHE_EN.
- Enabled:
  - Per-channel last-address/last-data register plus valid bit; valid bits clear on reset.
  - In IDLE, if the granted channel's address equals its cached address and valid=1, skip ISSUE. Go straight to DONE with chack[g]=1 and chdata=cached data, 2 cycles total, romreq stays 0.
  - Each completed ROM access updates the cache of that channel only.
  - ptr advances as normal.
- Disabled: every grant issues a ROM access; no cache registers are generated.

Test Plan:
- Reset mid-ISSUE:
  - Stimulus: reset_n=0 while romreq=1, then romack arrives during reset.
  - Response: romreq=0, chack=0, state IDLE; no chack afterward.
- Single request:
  - Stimulus: NCH=4, BASE slice 2=0x10000; chreq[2]=1, chaddr[2]=0x0123; ROM responds romdata=0xA5 after 3 cycles.
  - Response: romaddr=0x010123; chack=4'b0100 for one cycle with chdata=0xA5; romreq falls the same edge.
- Round-robin:
  - Stimulus: chreq=4'b1111 held; ROM acks 1 cycle after req.
  - Response: chack order 0001,0010,0100,1000,0001; never two bits set.
- Wrap:
  - Stimulus: BASE=0x3FFFF0, chaddr=0x20.
  - Response: romaddr=0x000010.
- Withdrawal:
  - Stimulus: chreq[1] dropped during ISSUE.
  - Response: access completes, chack[1] pulses once, next grant proceeds normally.
- Cache (ROMARB_RR_CACHE_EN):
  - Stimulus: read ch0 addr 0x55 twice.
  - Response: first read 1 romreq; second read chack 2 cycles after request with identical data, romreq stays 0. A third read at addr 0x56 issues a ROM access.
